piso_bit_serializer: RTL and testbench

//  Parallel-in/serial-out stage directly upstream of the Moore sequence FSM.

---
 rtl/piso_bit_serializer_pkg.sv | 14 +
 rtl/piso_bit_serializer_if.sv | 21 ++
 rtl/piso_bit_serializer_bit_tick_gen.sv | 33 +++
 rtl/piso_bit_serializer.sv | 87 ++++++++
 tb/tb_piso_bit_serializer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out bit serializer.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Counter width that never collapses to zero bits for trivial ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Word-in / serial-out handshake bundle between the word source and the serializer.
interface piso_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             x_valid;
  logic             frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, x_out, x_valid, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x_out, x_valid, frame_done
  );
endinterface

// File: rtl/piso_bit_serializer_bit_tick_gen.sv
// Per-bit clock divider: tick marks the last clock of each serial bit period.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned    DW   = clog2_min1(BIT_DIV);
  localparam logic [DW-1:0]  TERM = DW'(BIT_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = run && (div_cnt == TERM);

  // With BIT_DIV=1, TERM is 0 so the counter stays at 0 and every clock ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      if (div_cnt == TERM) div_cnt <= '0;
      else                 div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and
// streams them gap-free onto x_out, each bit held for BIT_DIV clocks.
module piso_bit_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BIT_DIV   = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  piso_bit_serializer_if.slave   bus
);

  localparam int unsigned   BW      = clog2_min1(WIDTH);
  localparam int unsigned   OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  piso_state_e      state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic             in_shift, tick, last, ready, accept;

  assign in_shift = (state == ST_SHIFT);
  assign last     = in_shift && tick && (bit_cnt == LAST_BIT);
  // Ready also depends on rst_n so nothing is offered while reset is held.
  assign ready    = rst_n && (!in_shift || last);
  assign accept   = bus.din_valid && ready;

  bit_tick_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .run   (in_shift),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shreg_d   = bus.din;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shreg_d   = bus.din;
          bit_cnt_d = '0;
        end else if (last) begin
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else if (tick) begin
          shreg_d   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  assign bus.x_out      = in_shift ? shreg[OUT_IDX] : IDLE_BIT;
  assign bus.x_valid    = in_shift;
  assign bus.frame_done = last;
  assign bus.din_ready  = ready;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: vector table, corner sequences and random
// traffic on two configurations, checked against a per-clock bit-queue model.
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_bit_serializer_if #(.WIDTH(8)) bus0 ();
  piso_bit_serializer_if #(.WIDTH(8)) bus1 ();

  piso_bit_serializer #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  piso_bit_serializer #(.WIDTH(8), .BIT_DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: one queue entry per clock the line will carry frame data.
  typedef struct packed { logic b; logic last; } ent_t;
  ent_t q0[$];
  ent_t q1[$];

  logic s0_x, s0_xv, s0_done, s0_rdy;
  logic s1_x, s1_xv, s1_done, s1_rdy;

  typedef struct { logic v; logic [7:0] d; logic x; logic xv; logic done; logic rdy; } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic push_frame(input int which, input logic [7:0] d, input int unsigned div, input bit msb);
    ent_t e;
    for (int i = 0; i < 8; i++) begin
      for (int unsigned k = 0; k < div; k++) begin
        e.b    = msb ? d[7-i] : d[i];
        e.last = (i == 7) && (k == div - 1);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
      end
    end
  endtask

  // One clock: drive, sample on negedge against the model, advance model on posedge.
  task automatic cycle(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    logic e_rdy0, e_rdy1;
    bus0.din_valid = v0; bus0.din = d0;
    bus1.din_valid = v1; bus1.din = d1;
    @(negedge clk);
    s0_x = bus0.x_out; s0_xv = bus0.x_valid; s0_done = bus0.frame_done; s0_rdy = bus0.din_ready;
    s1_x = bus1.x_out; s1_xv = bus1.x_valid; s1_done = bus1.frame_done; s1_rdy = bus1.din_ready;
    e_rdy0 = (q0.size() == 0) || q0[0].last;
    e_rdy1 = (q1.size() == 0) || q1[0].last;
    chk("m0_x",     s0_x,    q0.size() != 0 ? q0[0].b : 1'b1);
    chk("m0_valid", s0_xv,   q0.size() != 0);
    chk("m0_done",  s0_done, q0.size() != 0 ? q0[0].last : 1'b0);
    chk("m0_ready", s0_rdy,  e_rdy0);
    chk("m1_x",     s1_x,    q1.size() != 0 ? q1[0].b : 1'b1);
    chk("m1_valid", s1_xv,   q1.size() != 0);
    chk("m1_done",  s1_done, q1.size() != 0 ? q1[0].last : 1'b0);
    chk("m1_ready", s1_rdy,  e_rdy1);
    @(posedge clk);
    if (q0.size() != 0) void'(q0.pop_front());
    if (q1.size() != 0) void'(q1.pop_front());
    if (v0 && e_rdy0) push_frame(0, d0, 1, 1'b1);
    if (v1 && e_rdy1) push_frame(1, d1, 3, 1'b0);
    #1;
  endtask

  initial begin
    logic [7:0]  pat1;
    logic [15:0] seq2;
    logic [7:0]  pat4;
    logic [7:0]  pat6;
    bus0.din_valid = 1'b0; bus0.din = '0;
    bus1.din_valid = 1'b0; bus1.din = '0;

    // Reset state while rst_n is held low.
    #7;
    chk("rst_x0",     bus0.x_out,      1'b1);
    chk("rst_valid0", bus0.x_valid,    1'b0);
    chk("rst_done0",  bus0.frame_done, 1'b0);
    chk("rst_ready0", bus0.din_ready,  1'b0);
    chk("rst_x1",     bus1.x_out,      1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: single A5 frame, then back-to-back F0/0F.
    pat1 = 8'b10100101;
    seq2 = 16'b1111000000001111;
    tab.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 8; i++)
      tab.push_back('{1'b0, 8'h00, pat1[7-i], 1'b1, logic'(i == 7), logic'(i == 7)});
    tab.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    tab.push_back('{1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 16; i++)
      tab.push_back('{logic'(i < 8), 8'h0F, seq2[15-i], 1'b1,
                      logic'(i == 7 || i == 15), logic'(i == 7 || i == 15)});
    tab.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    foreach (tab[i]) begin
      cycle(tab[i].v, tab[i].d, 1'b0, 8'h00);
      chk($sformatf("tab%0d_x", i),     s0_x,    tab[i].x);
      chk($sformatf("tab%0d_valid", i), s0_xv,   tab[i].xv);
      chk($sformatf("tab%0d_done", i),  s0_done, tab[i].done);
      chk($sformatf("tab%0d_ready", i), s0_rdy,  tab[i].rdy);
    end

    // BIT_DIV=3, LSB-first, 8'h01: three clocks of 1 then 21 of 0.
    cycle(1'b0, 8'h00, 1'b1, 8'h01);
    for (int c = 1; c <= 24; c++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
      chk($sformatf("div3_x_c%0d", c),    s1_x,    logic'(c <= 3));
      chk($sformatf("div3_done_c%0d", c), s1_done, logic'(c == 24));
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    chk("div3_idle_valid", s1_xv, 1'b0);

    // din_valid pulsed mid-frame is ignored.
    cycle(1'b1, 8'hA5, 1'b0, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      cycle(logic'(c == 4), 8'h3C, 1'b0, 8'h00);
      chk($sformatf("pulse_x_c%0d", c), s0_x, pat1[8-c]);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pulse_not_taken", s0_xv, 1'b0);

    // din_valid held from mid-frame: taken at the frame's last clock.
    pat4 = 8'b00111100;
    cycle(1'b1, 8'hA5, 1'b0, 8'h00);
    for (int c = 1; c <= 16; c++) begin
      cycle(logic'(c >= 4 && c <= 8), 8'h3C, 1'b0, 8'h00);
      chk($sformatf("held_x_c%0d", c), s0_x, c <= 8 ? pat1[8-c] : pat4[16-c]);
      chk($sformatf("held_valid_c%0d", c), s0_xv, 1'b1);
    end

    // Chained-FSM pattern 0110_0011 MSB first.
    pat6 = 8'b01100011;
    cycle(1'b1, 8'h63, 1'b0, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
      chk($sformatf("fsm_x_c%0d", c), s0_x, pat6[8-c]);
    end

    // Async reset mid-frame (cycle 3 of A5).
    cycle(1'b1, 8'hA5, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x",     bus0.x_out,     1'b1);
    chk("arst_valid", bus0.x_valid,   1'b0);
    chk("arst_ready", bus0.din_ready, 1'b0);
    q0.delete(); q1.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst_ready_after", bus0.din_ready, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) cycle(1'b0, 8'h00, 1'b0, 8'h00);

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++)
      cycle(logic'($urandom_range(0, 3) != 0), 8'($urandom),
            logic'($urandom_range(0, 3) == 0), 8'($urandom));
    for (int c = 0; c < 30; c++) cycle(1'b0, 8'h00, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
